// File: rtl/obstacle_gen.sv
// obstacle_gen: schedules, scrolls and retires up to two obstacles and flags collisions with the dinosaur.
module obstacle_gen #(
    parameter int SCREEN_W = 160,
    parameter int OBS_W    = 4,
    parameter int OBS_H    = 8,
    parameter int DINO_X   = 20,
    parameter int DINO_W   = 6,
    parameter int MIN_GAP  = 40
) (
    input  logic       Clock,
    input  logic       resetn,
    input  logic       tick,
    input  logic       enable,
    input  logic       clear,
    input  logic [7:0] dino_y,
    output logic       gen,
    output logic       lose,
    output logic [1:0] obs_valid,
    output logic [7:0] obs0_x,
    output logic [7:0] obs1_x,
    output logic [7:0] passed
);
    localparam logic [7:0] SPAWN_X = 8'(SCREEN_W - 1);
    localparam logic [7:0] GAP     = 8'(MIN_GAP);
    localparam logic [8:0] XHI     = 9'(DINO_X + DINO_W - 1);
    localparam logic [8:0] XLO     = 9'(DINO_X);
    localparam logic [8:0] OW      = 9'(OBS_W);

    logic [7:0] lfsr, cnt, x0m, x1m, psat, reload;
    logic [8:0] sum;
    logic [1:0] ret, free;
    logic       active, spawn, s0, s1, hit;

    // x + OBS_W - 1 >= DINO_X rewritten as x + OBS_W > DINO_X to stay unsigned
    function automatic logic ov(input logic [7:0] x);
        return {1'b0, x} <= XHI && {1'b0, x} + OW > XLO;
    endfunction

    always_comb begin
        ret    = obs_valid & {obs1_x == 8'd0, obs0_x == 8'd0};
        free   = ~obs_valid | ret;
        active = tick && enable && !lose && !clear;
        spawn  = active && cnt <= 8'd1 && |free;
        s0     = spawn && free[0];
        s1     = spawn && !free[0];
        hit    = dino_y < 8'(OBS_H) && |(obs_valid & {ov(obs1_x), ov(obs0_x)});
        sum    = {1'b0, passed} + 9'(ret[0]) + 9'(ret[1]);
        psat   = sum[8] ? 8'hFF : sum[7:0];
        x0m    = obs_valid[0] && obs0_x != 8'd0 ? obs0_x - 8'd1 : obs0_x;
        x1m    = obs_valid[1] && obs1_x != 8'd0 ? obs1_x - 8'd1 : obs1_x;
        reload = GAP + {3'b000, lfsr[4:0]};
    end

    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            lfsr      <= 8'hA5;
            gen       <= 1'b0;
            lose      <= 1'b0;
            obs_valid <= 2'b00;
            obs0_x    <= 8'd0;
            obs1_x    <= 8'd0;
            passed    <= 8'd0;
            cnt       <= GAP;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            gen  <= spawn;
            if (clear) begin
                lose      <= 1'b0;
                obs_valid <= 2'b00;
                obs0_x    <= 8'd0;
                obs1_x    <= 8'd0;
                passed    <= 8'd0;
                cnt       <= GAP;
            end else begin
                lose <= lose | hit;
                if (active) begin
                    // a slot retiring this tick is already counted free, so a pending spawn reuses it
                    obs_valid <= (obs_valid & ~ret) | {s1, s0};
                    obs0_x    <= s0 ? SPAWN_X : x0m;
                    obs1_x    <= s1 ? SPAWN_X : x1m;
                    passed    <= psat;
                    cnt       <= spawn ? reload : (cnt != 8'd0 ? cnt - 8'd1 : 8'd0);
                end
            end
        end
    end
endmodule

// File: tb/tb_obstacle_gen.sv
// tb_obstacle_gen: directed vectors and multi-cycle sequences for obstacle_gen.
module tb_obstacle_gen;
    logic       Clock = 1'b0;
    logic       resetn = 1'b1;
    logic       tick = 1'b0, enable = 1'b0, clear = 1'b0;
    logic [7:0] dino_y = 8'd20;
    logic       gen, lose;
    logic [1:0] obs_valid;
    logic [7:0] obs0_x, obs1_x, passed;

    obstacle_gen dut (
        .Clock(Clock), .resetn(resetn), .tick(tick), .enable(enable), .clear(clear),
        .dino_y(dino_y), .gen(gen), .lose(lose), .obs_valid(obs_valid),
        .obs0_x(obs0_x), .obs1_x(obs1_x), .passed(passed)
    );

    always #5 Clock = ~Clock;

    // reference LFSR, x^8+x^6+x^5+x^4+1, free-running from reset
    logic [7:0] m_lfsr;
    always_ff @(posedge Clock or negedge resetn)
        if (!resetn) m_lfsr <= 8'hA5;
        else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

    typedef struct packed {
        logic       t, e, c;
        logic [7:0] y;
        logic       g, l;
        logic [1:0] v;
        logic [7:0] x0, p;
    } vec_t;

    vec_t       tbl [8];
    int         checks = 0, errors = 0;
    int         reload = 0, r1 = 0, n = 0, hits = 0;
    logic [7:0] pre_l;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input logic t, input logic e, input logic c, input logic [7:0] y);
        tick = t; enable = e; clear = c; dino_y = y;
        pre_l = m_lfsr;
        @(posedge Clock);
        #1;
        if (gen) reload = 40 + int'(pre_l[4:0]);
    endtask

    task automatic ticks(input int k, input logic [7:0] y);
        for (int i = 0; i < k; i++) cyc(1'b1, 1'b1, 1'b0, y);
    endtask

    task automatic until_gen(input logic [7:0] y, output int cnt);
        cnt = 0;
        do begin
            cyc(1'b1, 1'b1, 1'b0, y);
            cnt++;
        end while (!gen && cnt < 300);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gen"}, 32'(gen), 0);
        chk({tag, "_lose"}, 32'(lose), 0);
        chk({tag, "_valid"}, 32'(obs_valid), 0);
        chk({tag, "_x0"}, 32'(obs0_x), 0);
        chk({tag, "_x1"}, 32'(obs1_x), 0);
        chk({tag, "_passed"}, 32'(passed), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //            t     e     c     y      g     l     v      x0      p
        tbl[0] = {1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 2'd3, 8'd26, 8'd0};
        tbl[1] = {1'b1, 1'b1, 1'b0, 8'd20, 1'b0, 1'b0, 2'd3, 8'd25, 8'd0};
        tbl[2] = {1'b0, 1'b1, 1'b0, 8'd20, 1'b0, 1'b0, 2'd3, 8'd25, 8'd0};
        tbl[3] = {1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b1, 2'd3, 8'd25, 8'd0};
        tbl[4] = {1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b1, 2'd3, 8'd25, 8'd0};
        tbl[5] = {1'b1, 1'b1, 1'b0, 8'd20, 1'b0, 1'b1, 2'd3, 8'd25, 8'd0};
        tbl[6] = {1'b1, 1'b1, 1'b1, 8'd0,  1'b0, 1'b0, 2'd0, 8'd0,  8'd0};
        tbl[7] = {1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 2'd0, 8'd0,  8'd0};

        #1 resetn = 1'b0;
        #10 chk_all_zero("reset");
        @(negedge Clock) resetn = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 8'd20);
        chk_all_zero("clear");

        until_gen(8'd20, n);
        chk("first_spawn_tick", n, 40);
        chk("first_spawn_valid", 32'(obs_valid), 1);
        chk("first_spawn_x0", 32'(obs0_x), 159);
        chk("first_spawn_lose", 32'(lose), 0);
        r1 = reload;
        until_gen(8'd20, n);
        chk("second_spawn_gap", n, r1);
        chk("second_spawn_valid", 32'(obs_valid), 3);
        chk("second_spawn_x1", 32'(obs1_x), 159);
        chk("second_spawn_x0", 32'(obs0_x), 159 - r1);

        hits = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'd20);
            if (gen) hits++;
        end
        chk("pause_gen", hits, 0);
        chk("pause_x0", 32'(obs0_x), 159 - r1);
        chk("pause_x1", 32'(obs1_x), 159);
        chk("pause_valid", 32'(obs_valid), 3);
        cyc(1'b1, 1'b1, 1'b0, 8'd20);
        chk("resume_gen", 32'(gen), 0);
        chk("resume_x0", 32'(obs0_x), 158 - r1);

        ticks(132 - r1, 8'd20);
        chk("scroll_x0", 32'(obs0_x), 26);
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].t, tbl[i].e, tbl[i].c, tbl[i].y);
            chk($sformatf("vec%0d_gen", i), 32'(gen), 32'(tbl[i].g));
            chk($sformatf("vec%0d_lose", i), 32'(lose), 32'(tbl[i].l));
            chk($sformatf("vec%0d_valid", i), 32'(obs_valid), 32'(tbl[i].v));
            chk($sformatf("vec%0d_x0", i), 32'(obs0_x), 32'(tbl[i].x0));
            chk($sformatf("vec%0d_passed", i), 32'(passed), 32'(tbl[i].p));
        end

        until_gen(8'd20, n);
        chk("countdown_after_clear", n, 40);
        ticks(133, 8'd20);
        ticks(4, 8'd8);
        chk("jump_x0", 32'(obs0_x), 22);
        chk("jump_over_lose", 32'(lose), 0);
        cyc(1'b0, 1'b1, 1'b0, 8'd8);
        chk("jump_idle_lose", 32'(lose), 0);
        cyc(1'b0, 1'b1, 1'b0, 8'd3);
        chk("land_on_obstacle_lose", 32'(lose), 1);
        cyc(1'b0, 1'b1, 1'b1, 8'd20);
        chk("clear_after_land_lose", 32'(lose), 0);

        until_gen(8'd20, n);
        ticks(143, 8'd8);
        chk("edge16_x0", 32'(obs0_x), 16);
        chk("edge16_jump_lose", 32'(lose), 0);
        cyc(1'b0, 1'b1, 1'b0, 8'd0);
        chk("edge16_ground_lose", 32'(lose), 0);
        ticks(16, 8'd20);
        chk("at_zero_x0", 32'(obs0_x), 0);
        chk("at_zero_valid", 32'(obs_valid), 3);
        chk("at_zero_passed", 32'(passed), 0);
        cyc(1'b1, 1'b1, 1'b0, 8'd20);
        chk("retire_spawn_gen", 32'(gen), 1);
        chk("retire_spawn_x0", 32'(obs0_x), 159);
        chk("retire_spawn_valid", 32'(obs_valid), 3);
        chk("retire_spawn_passed", 32'(passed), 1);
        cyc(1'b1, 1'b1, 1'b0, 8'd20);
        chk("after_retire_gen", 32'(gen), 0);
        chk("after_retire_x0", 32'(obs0_x), 158);

        #2 resetn = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge Clock) resetn = 1'b1;
        until_gen(8'd20, n);
        chk("post_reset_spawn_tick", n, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/obstacle_gen.md
# obstacle_gen

Obstacle generator and collision detector for the dinosaur game. It schedules obstacles at pseudo-random spacing and scrolls up to two of them across the screen on each frame tick. It flags collisions with the dinosaur and feeds the `gen` and `lose` inputs of the game control FSM. It sits between the frame-tick source and jump physics on one side and the control FSM and VGA renderer on the other.

## Interface
- `SCREEN_W`, 160: obstacle spawn column is SCREEN_W-1; must be ≤ 256.
- `OBS_W`, 4: obstacle width in pixels.
- `OBS_H`, 8: obstacle height; the dinosaur clears an obstacle when `dino_y` ≥ OBS_H.
- `DINO_X`, 20: leftmost dinosaur column.
- `DINO_W`, 6: dinosaur width in pixels.
- `MIN_GAP`, 40: minimum number of ticks between spawns; must be ≥ 1 and MIN_GAP+31 ≤ 255.

Ports:
- `Clock` in 1: system clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle frame pulse.
- `enable` in 1: high while the game runs; low during pause and menu.
- `clear` in 1: synchronous new-game clear.
- `dino_y` in 8: dinosaur height above ground, in pixels.
- `gen` out 1: one-cycle pulse when an obstacle spawns.
- `lose` out 1: sticky collision flag.
- `obs_valid` out 2: per-slot valid bits.
- `obs0_x` out 8: slot 0 column.
- `obs1_x` out 8: slot 1 column.
- `passed` out 8: count of obstacles cleared, saturating at 255.

## Operation
**LFSR**
- 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
- Advances every clock cycle regardless of `enable`, `tick` or `clear`.
- Reset value 8'hA5. `clear` does not reseed it.

**Active tick**
- An active tick is `tick` && `enable` && !`lose` && !`clear`.
- All other cycles hold slots, countdown and `passed`.

**Processing order within one active tick**
1. Move: every valid slot with x > 0 gets x ← x-1.
2. Retire: a valid slot with x == 0 is invalidated and `passed` increments, saturating at 255.
3. Countdown: if the countdown is > 0, it decrements.
4. Spawn: if the countdown was already 0 at the tick, or reaches 0 on this tick, and a free slot exists after the retire step:
   - load the lowest-index free slot with x = SCREEN_W-1 and set its valid bit;
   - pulse `gen`;
   - reload countdown ← MIN_GAP + lfsr[4:0].
5. Pending spawn: if no slot is free, the countdown stays at 0 and the spawn fires on the first active tick that has a free slot.

**Collision**
- Evaluated combinationally on the registered state.
- A valid slot overlaps when x ≤ DINO_X+DINO_W-1 and x+OBS_W-1 ≥ DINO_X.
- Collision = any overlapping slot && `dino_y` < OBS_H.
- Collision sets `lose` at the next clock edge.
- `lose` stays high until `clear` or reset, and freezes all motion.

**Clear**
- Next cycle: all slots invalid, x = 0, countdown = MIN_GAP, `passed` = 0, `lose` = 0, `gen` = 0.
- `clear` has priority over `tick` and collision.

**Reset values**
- `gen` = 0, `lose` = 0, `obs_valid` = 2'b00, `obs0_x` = `obs1_x` = 0, `passed` = 0.
- Countdown = MIN_GAP, LFSR = 8'hA5.

## Timing
- All outputs are registered.
- Active tick at edge N: new positions and the `gen` pulse are visible after edge N, and `gen` stays high exactly 1 cycle.
- `lose` rises at the edge after the overlapping state first becomes visible, i.e. 1 cycle of collision latency.
- `dino_y` is sampled every cycle, so a jump ending while an obstacle is under the dinosaur triggers `lose` without waiting for a tick.
- `enable` low holds state indefinitely; resuming does not produce a spurious `gen`.
- `resetn` asserted mid-game forces the reset values immediately, without waiting for `Clock`.
- Release of `resetn` is synchronised externally.
- Simultaneous events:
  - `tick` and `clear` in the same cycle: `clear` wins.
  - retire and spawn on the same tick: the freed slot may be reused on that tick.
  - collision check on the same cycle as a tick: it uses pre-tick positions; the post-tick overlap is caught next cycle.

## Test plan
- Reset, then `clear`, then 40 active ticks with `dino_y` = 20 → first `gen` on tick 40, slot 0 valid at x = 159, `lose` stays 0.
- Continuous ticks with `dino_y` = 20 → spawn gaps all within 40..71 ticks; `passed` increments by 1 on each x==0 retire; no more than 2 slots ever valid.
- `dino_y` = 0, obstacle scrolled to x = 25 → `lose` = 1 one cycle later; further ticks leave `obs0_x` = 25; `clear` → all outputs return to 0 and countdown = 40.
- Obstacle at x = 22 with `dino_y` = 8, then `dino_y` dropped to 3 with no tick → `lose` rises 1 cycle after the drop.
- `enable` = 0 for 100 ticks mid-game → positions, countdown and `passed` unchanged, and `gen` = 0 throughout.
- Both slots valid when the countdown hits 0 → no spawn until a slot retires; spawn lands in the freed slot on the same tick, with a single `gen`.
- `resetn` pulsed low asynchronously mid-frame → outputs cleared within the pulse, with no `Clock` edge required.
